simd_permute_unit: RTL and testbench

- Parametrised next-generation SIMD permutation engine: NumElems = NumLanes*NumBanks elements of XLEN bits in, permuted vector out.
- Adds over the previous generation:
  - configurable element count and pipeline depth;
  - rotate, reverse, transpose, broadcast and indexed-gather modes;
  - a stored gather index vector with its own load handshake;
  - full ready/valid back-pressure through every stage.
- Sits between the vector register-file read crossbar and the lane ALUs.

---
 rtl/simd_perm_pkg.sv | 14 +
 rtl/simd_perm_xbar.sv | 42 ++++
 rtl/simd_permute_unit.sv | 120 ++++++++++++
 tb/tb_simd_permute_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_perm_pkg.sv
// simd_perm_pkg: permutation mode encoding and transpose index mapping
package simd_perm_pkg;
  typedef enum logic [2:0] {
    PASS      = 3'd0,
    ROTATE    = 3'd1,
    REVERSE   = 3'd2,
    TRANSPOSE = 3'd3,
    BROADCAST = 3'd4,
    GATHER    = 3'd5
  } perm_mode_e;
  function automatic int transpose_src(input int e, input int lanes, input int banks);
    return (e % lanes) * banks + e / lanes;
  endfunction
endpackage

// File: rtl/simd_perm_xbar.sv
// simd_perm_xbar: combinational element permutation; SIMD_PERM_OOR_ZERO_EN zeroes out-of-range gather elements
module simd_perm_xbar import simd_perm_pkg::*; #(
  parameter int XLEN     = 64,
  parameter int NumLanes = 8,
  parameter int NumBanks = 8,
  parameter int IW       = 6
) (
  input  logic [NumLanes*NumBanks*XLEN-1:0]       data,
  input  logic [2:0]                              mode,
  input  logic [$clog2(NumLanes*NumBanks)-1:0]    arg,
  input  logic [NumLanes*NumBanks*IW-1:0]         idx,
  output logic [NumLanes*NumBanks*XLEN-1:0]       out
`ifdef SIMD_PERM_OOR_ZERO_EN
  , output logic                                  oor
`endif
);
  localparam int NumElems = NumLanes * NumBanks;
  localparam int SW = $clog2(NumElems);
`ifdef SIMD_PERM_OOR_ZERO_EN
  logic [NumElems-1:0] zero;
  assign oor = |zero;
`endif
  for (genvar e = 0; e < NumElems; e++) begin : g_el
    localparam logic [SW-1:0] E = SW'(e);
    localparam logic [SW-1:0] R = SW'(NumElems - 1 - e);
    localparam logic [SW-1:0] T = SW'(transpose_src(e, NumLanes, NumBanks));
    logic [IW-1:0] ie;
    logic [SW-1:0] src;
    assign ie = idx[e*IW +: IW];
    assign src = mode == ROTATE    ? E + arg :
                 mode == REVERSE   ? R :
                 mode == TRANSPOSE ? T :
                 mode == BROADCAST ? arg :
                 mode == GATHER    ? ie[SW-1:0] : E;
`ifdef SIMD_PERM_OOR_ZERO_EN
    assign zero[e] = mode == GATHER && ie[IW-1];
    assign out[e*XLEN +: XLEN] = zero[e] ? '0 : data[int'(src)*XLEN +: XLEN];
`else
    assign out[e*XLEN +: XLEN] = data[int'(src)*XLEN +: XLEN];
`endif
  end
endmodule

// File: rtl/simd_permute_unit.sv
// simd_permute_unit: pipelined SIMD permutation with gather index register; SIMD_PERM_OOR_ZERO_EN adds io_oorFlag
module simd_permute_unit import simd_perm_pkg::*; #(
  parameter int XLEN      = 64,
  parameter int NumLanes  = 8,
  parameter int NumBanks  = 8,
  parameter int NumStages = 2,
  localparam int NumElems = NumLanes * NumBanks,
  localparam int IdxW     = $clog2(NumElems) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_inValid,
  output logic                     io_inReady,
  input  logic [NumElems*XLEN-1:0] io_inData,
  input  logic [2:0]               io_mode,
  input  logic [IdxW-2:0]          io_arg,
  input  logic                     io_selIdxVal,
  output logic                     io_outValid,
  input  logic                     io_outReady,
  output logic [NumElems*XLEN-1:0] io_outData,
  output logic                     io_busy
`ifdef SIMD_PERM_OOR_ZERO_EN
  , output logic                   io_oorFlag
`endif
);
  localparam int DW = NumElems * XLEN;
`ifdef SIMD_PERM_OOR_ZERO_EN
  localparam int IW = IdxW;
`else
  localparam int IW = IdxW - 1;
`endif
  logic v0_q, v0_d, nxt_rdy, in_fire, beat, idx_load;
  logic [DW-1:0] data0_q, data0_d, perm;
  logic [2:0] mode0_q, mode0_d;
  logic [IdxW-2:0] arg0_q, arg0_d;
  logic [NumElems*IW-1:0] idx_q, idx_d, idx0_q, idx0_d, idx_in, idx_rst;
  for (genvar e = 0; e < NumElems; e++) begin : g_idx
    assign idx_in[e*IW +: IW] = io_inData[e*XLEN +: IW];
    assign idx_rst[e*IW +: IW] = IW'(e);
  end
  assign io_inReady = !v0_q || nxt_rdy;
  always_comb begin
    in_fire = io_inValid && io_inReady;
    beat = in_fire && !io_selIdxVal;
    idx_load = in_fire && io_selIdxVal;
    v0_d = io_inReady ? beat : v0_q;
    data0_d = beat ? io_inData : data0_q;
    mode0_d = beat ? io_mode : mode0_q;
    arg0_d = beat ? io_arg : arg0_q;
    idx0_d = beat ? idx_q : idx0_q;
    idx_d = idx_load ? idx_in : idx_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      v0_q <= 1'b0;
      data0_q <= '0;
      mode0_q <= PASS;
      arg0_q <= '0;
      idx0_q <= idx_rst;
      idx_q <= idx_rst;
    end else begin
      v0_q <= v0_d;
      data0_q <= data0_d;
      mode0_q <= mode0_d;
      arg0_q <= arg0_d;
      idx0_q <= idx0_d;
      idx_q <= idx_d;
    end
  end
`ifdef SIMD_PERM_OOR_ZERO_EN
  logic perm_oor;
`endif
  simd_perm_xbar #(
    .XLEN(XLEN), .NumLanes(NumLanes), .NumBanks(NumBanks), .IW(IW)
  ) u_xbar (
    .data(data0_q),
    .mode(mode0_q),
    .arg(arg0_q),
    .idx(idx0_q),
    .out(perm)
`ifdef SIMD_PERM_OOR_ZERO_EN
    , .oor(perm_oor)
`endif
  );
  if (NumStages == 2) begin : g_s2
    logic v1_q, v1_d;
    logic [DW-1:0] data1_q, data1_d;
    assign nxt_rdy = !v1_q || io_outReady;
    always_comb begin
      v1_d = nxt_rdy ? v0_q : v1_q;
      data1_d = nxt_rdy && v0_q ? perm : data1_q;
    end
    always_ff @(posedge clock) begin
      if (!reset) begin
        v1_q <= 1'b0;
        data1_q <= '0;
      end else begin
        v1_q <= v1_d;
        data1_q <= data1_d;
      end
    end
`ifdef SIMD_PERM_OOR_ZERO_EN
    logic oor1_q, oor1_d;
    always_comb oor1_d = nxt_rdy && v0_q ? perm_oor : oor1_q;
    always_ff @(posedge clock) oor1_q <= !reset ? 1'b0 : oor1_d;
    assign io_oorFlag = v1_q && oor1_q;
`endif
    assign io_outValid = v1_q;
    assign io_outData = data1_q;
    assign io_busy = v0_q || v1_q;
  end else begin : g_s1
    assign nxt_rdy = io_outReady;
`ifdef SIMD_PERM_OOR_ZERO_EN
    assign io_oorFlag = v0_q && perm_oor;
`endif
    assign io_outValid = v0_q;
    assign io_outData = perm;
    assign io_busy = v0_q;
  end
endmodule

// File: tb/tb_simd_permute_unit.sv
// tb_simd_permute_unit: directed self-checking bench for simd_permute_unit
module tb_simd_permute_unit;
  localparam int N = 64;
  localparam int X = 64;
  localparam int DW = N * X;
  logic clock = 1'b0, reset = 1'b0;
  logic io_inValid = 1'b0, io_inReady, io_selIdxVal = 1'b0;
  logic io_outValid, io_outReady = 1'b1, io_busy;
  logic [DW-1:0] io_inData = '0, io_outData;
  logic [2:0] io_mode = 3'd0;
  logic [5:0] io_arg = 6'd0;
`ifdef SIMD_PERM_OOR_ZERO_EN
  logic io_oorFlag, last_oor;
`endif
  int checks = 0, passed = 0;
  int gidx[N];
  always #5 clock = ~clock;
  simd_permute_unit dut (
    .clock(clock), .reset(reset),
    .io_inValid(io_inValid), .io_inReady(io_inReady), .io_inData(io_inData),
    .io_mode(io_mode), .io_arg(io_arg), .io_selIdxVal(io_selIdxVal),
    .io_outValid(io_outValid), .io_outReady(io_outReady), .io_outData(io_outData),
    .io_busy(io_busy)
`ifdef SIMD_PERM_OOR_ZERO_EN
    , .io_oorFlag(io_oorFlag)
`endif
  );
  function automatic logic [DW-1:0] vec(input int base);
    logic [DW-1:0] v;
    for (int e = 0; e < N; e++) v[e*X +: X] = 64'(base + e);
    return v;
  endfunction
  function automatic logic [63:0] el(input logic [DW-1:0] v, input int e);
    return (e < 0) ? 64'hx : v[e*X +: X];
  endfunction
  function automatic int first_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int e = 0; e < N; e++) if (a[e*X +: X] !== b[e*X +: X]) return e;
    return -1;
  endfunction
  function automatic logic [DW-1:0] model(input int m, input int a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    int s;
    r = '0;
    for (int e = 0; e < N; e++) begin
      s = m == 1 ? (e + a) % N : m == 2 ? N - 1 - e : m == 3 ? (e % 8) * 8 + e / 8 :
          m == 4 ? a % N : m == 5 ? gidx[e] % N : e;
      r[e*X +: X] = d[s*X +: X];
`ifdef SIMD_PERM_OOR_ZERO_EN
      if (m == 5 && gidx[e] >= N) r[e*X +: X] = '0;
`endif
    end
    return r;
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [2:0] m, input logic [5:0] a, input logic [DW-1:0] d, input logic sel);
    int n = 0;
    io_inValid = 1'b1; io_mode = m; io_arg = a; io_inData = d; io_selIdxVal = sel;
    #1;
    while (!io_inReady && n < 20) begin tick(); n++; end
    checks++;
    if (io_inReady !== 1'b1) $display("FAIL send_ready: inReady=%b after %0d cycles, want 1", io_inReady, n);
    else passed++;
    tick();
    io_inValid = 1'b0; io_selIdxVal = 1'b0;
  endtask
  task automatic recv(output logic [DW-1:0] q);
    int n = 0;
    q = '0;
    while (!io_outValid && n < 20) begin tick(); n++; end
    checks++;
    if (io_outValid !== 1'b1) $display("FAIL recv_timeout: outValid=%b after %0d cycles, want 1", io_outValid, n);
    else begin
      passed++;
      q = io_outData;
`ifdef SIMD_PERM_OOR_ZERO_EN
      last_oor = io_oorFlag;
`endif
      tick();
    end
  endtask
  task automatic run(input logic [2:0] m, input logic [5:0] a, input logic [DW-1:0] d, output logic [DW-1:0] q);
    send(m, a, d, 1'b0);
    recv(q);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    for (int e = 0; e < N; e++) gidx[e] = e;
    tick(); tick();
    checks += 4;
    if (io_outValid !== 1'b0) $display("FAIL reset_outValid: got %b want 0", io_outValid); else passed++;
    if (io_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", io_busy); else passed++;
    if (io_outData !== '0) $display("FAIL reset_outData: elem %0d got %0h want 0", first_diff(io_outData, '0), el(io_outData, first_diff(io_outData, '0))); else passed++;
    if (io_inReady !== 1'b1) $display("FAIL reset_inReady: got %b want 1", io_inReady); else passed++;
    reset = 1'b1;
    tick();
  endtask
  task automatic test_pass();
    logic [DW-1:0] exp;
    exp = vec(0);
    send(3'd0, 6'd0, vec(0), 1'b0);
    checks += 2;
    if (io_outValid !== 1'b0) $display("FAIL pass_early_valid: got %b want 0", io_outValid); else passed++;
    if (io_busy !== 1'b1) $display("FAIL pass_busy: got %b want 1", io_busy); else passed++;
    tick();
    checks += 2;
    if (io_outValid !== 1'b1) $display("FAIL pass_latency: outValid=%b want 1", io_outValid); else passed++;
    if (io_outData !== exp) $display("FAIL pass_data: elem %0d got %0h want %0h", first_diff(io_outData, exp), el(io_outData, first_diff(io_outData, exp)), el(exp, first_diff(io_outData, exp))); else passed++;
    tick();
    checks++;
    if (io_outValid !== 1'b0) $display("FAIL pass_one_cycle: outValid=%b want 0", io_outValid); else passed++;
  endtask
  task automatic test_rotate();
    logic [DW-1:0] q, exp;
    run(3'd1, 6'd3, vec(0), q);
    exp = model(1, 3, vec(0));
    checks += 4;
    if (el(q, 0) !== 64'd3) $display("FAIL rot3_out0: got %0d want 3", el(q, 0)); else passed++;
    if (el(q, 60) !== 64'd63) $display("FAIL rot3_out60: got %0d want 63", el(q, 60)); else passed++;
    if (el(q, 61) !== 64'd0) $display("FAIL rot3_out61: got %0d want 0", el(q, 61)); else passed++;
    if (q !== exp) $display("FAIL rot3_vec: elem %0d got %0h want %0h", first_diff(q, exp), el(q, first_diff(q, exp)), el(exp, first_diff(q, exp))); else passed++;
    run(3'd1, 6'd0, vec(50), q);
    exp = vec(50);
    checks++;
    if (q !== exp) $display("FAIL rot0_vec: elem %0d got %0h want %0h", first_diff(q, exp), el(q, first_diff(q, exp)), el(exp, first_diff(q, exp))); else passed++;
    run(3'd6, 6'd9, vec(70), q);
    exp = vec(70);
    checks++;
    if (q !== exp) $display("FAIL reserved_vec: elem %0d got %0h want %0h", first_diff(q, exp), el(q, first_diff(q, exp)), el(exp, first_diff(q, exp))); else passed++;
  endtask
  task automatic test_reverse_transpose();
    logic [DW-1:0] q, exp;
    run(3'd2, 6'd0, vec(0), q);
    exp = model(2, 0, vec(0));
    checks += 2;
    if (el(q, 0) !== 64'd63) $display("FAIL rev_out0: got %0d want 63", el(q, 0)); else passed++;
    if (q !== exp) $display("FAIL rev_vec: elem %0d got %0h want %0h", first_diff(q, exp), el(q, first_diff(q, exp)), el(exp, first_diff(q, exp))); else passed++;
    run(3'd3, 6'd0, vec(0), q);
    checks += 3;
    if (el(q, 1) !== 64'd8) $display("FAIL tr_out1: got %0d want 8", el(q, 1)); else passed++;
    if (el(q, 8) !== 64'd1) $display("FAIL tr_out8: got %0d want 1", el(q, 8)); else passed++;
    if (el(q, 63) !== 64'd63) $display("FAIL tr_out63: got %0d want 63", el(q, 63)); else passed++;
    run(3'd4, 6'd5, vec(10), q);
    exp = model(4, 5, vec(10));
    checks++;
    if (q !== exp) $display("FAIL bcast_vec: elem %0d got %0h want %0h", first_diff(q, exp), el(q, first_diff(q, exp)), el(exp, first_diff(q, exp))); else passed++;
  endtask
  task automatic test_gather();
    logic [DW-1:0] ld, q, exp;
    for (int e = 0; e < N; e++) begin gidx[e] = 63 - e; ld[e*X +: X] = 64'(63 - e); end
    send(3'd0, 6'd0, ld, 1'b1);
    checks++;
    if (io_busy !== 1'b0) $display("FAIL idxload_busy: got %b want 0", io_busy); else passed++;
    run(3'd5, 6'd0, vec(100), q);
    exp = model(5, 0, vec(100));
    checks += 2;
    if (el(q, 0) !== 64'd163) $display("FAIL gather_out0: got %0d want 163", el(q, 0)); else passed++;
    if (q !== exp) $display("FAIL gather_vec: elem %0d got %0h want %0h", first_diff(q, exp), el(q, first_diff(q, exp)), el(exp, first_diff(q, exp))); else passed++;
  endtask
  task automatic test_oor();
    logic [DW-1:0] ld, q, exp;
    for (int e = 0; e < N; e++) begin gidx[e] = e; ld[e*X +: X] = 64'(e); end
    gidx[5] = 64;
    ld[5*X +: X] = 64'd64;
    send(3'd0, 6'd0, ld, 1'b1);
    run(3'd5, 6'd0, vec(200), q);
    exp = model(5, 0, vec(200));
    checks += 2;
`ifdef SIMD_PERM_OOR_ZERO_EN
    if (el(q, 5) !== 64'd0) $display("FAIL oor_out5: got %0d want 0", el(q, 5)); else passed++;
    checks++;
    if (last_oor !== 1'b1) $display("FAIL oor_flag: got %b want 1", last_oor); else passed++;
`else
    if (el(q, 5) !== 64'd200) $display("FAIL oor_wrap_out5: got %0d want 200", el(q, 5)); else passed++;
`endif
    if (q !== exp) $display("FAIL oor_vec: elem %0d got %0h want %0h", first_diff(q, exp), el(q, first_diff(q, exp)), el(exp, first_diff(q, exp))); else passed++;
  endtask
  task automatic test_back_to_back();
    logic [DW-1:0] rx[5];
    int sent = 0, got = 0;
    logic in_f, out_f;
    for (int c = 0; c < 40 && got < 5; c++) begin
      io_outReady = c >= 4;
      io_inValid = sent < 5; io_mode = 3'd0; io_arg = 6'd0; io_selIdxVal = 1'b0;
      io_inData = vec(1000 * sent);
      #1;
      if (c == 3) begin
        checks++;
        if (sent !== 2 || io_inReady !== 1'b0) $display("FAIL bp_full: accepted %0d inReady=%b, want 2 and 0", sent, io_inReady); else passed++;
      end
      in_f = io_inValid && io_inReady;
      out_f = io_outValid && io_outReady;
      if (out_f) begin
        if (got < 5) rx[got] = io_outData;
        got++;
      end
      tick();
      if (in_f) sent++;
    end
    io_inValid = 1'b0;
    io_outReady = 1'b1;
    tick(); tick();
    checks += 2;
    if (got !== 5) $display("FAIL bp_count: got %0d beats want 5", got); else passed++;
    if (io_outValid !== 1'b0 || io_busy !== 1'b0) $display("FAIL bp_drain: outValid=%b busy=%b want 0 0", io_outValid, io_busy); else passed++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx[k] !== vec(1000 * k)) $display("FAIL bp_order%0d: elem0 got %0d want %0d", k, el(rx[k], 0), 1000 * k); else passed++;
    end
  endtask
  task automatic test_reset_mid();
    logic [DW-1:0] q, exp;
    int seen = 0;
    io_outReady = 1'b0;
    send(3'd0, 6'd0, vec(500), 1'b0);
    send(3'd0, 6'd0, vec(600), 1'b0);
    reset = 1'b0;
    for (int e = 0; e < N; e++) gidx[e] = e;
    tick();
    checks += 2;
    if (io_outValid !== 1'b0) $display("FAIL rstmid_outValid: got %b want 0", io_outValid); else passed++;
    if (io_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", io_busy); else passed++;
    reset = 1'b1;
    io_outReady = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (io_outValid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) $display("FAIL rstmid_stale: saw %0d stale beats want 0", seen); else passed++;
    run(3'd5, 6'd0, vec(700), q);
    exp = vec(700);
    checks++;
    if (q !== exp) $display("FAIL rstmid_idx_ident: elem %0d got %0h want %0h", first_diff(q, exp), el(q, first_diff(q, exp)), el(exp, first_diff(q, exp))); else passed++;
  endtask
  initial begin
    test_reset();
    test_pass();
    test_rotate();
    test_reverse_transpose();
    test_gather();
    test_oor();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
